// File: rtl/snake_scoreboard_mux.sv
// snake_scoreboard_mux: binary score -> BCD (sequential double-dabble) ->
// time-multiplexed active-low seven-segment display with leading-zero
// blanking and blink. Scores that do not fit in NUM_DIGITS digits saturate to all 9s.
module snake_scoreboard_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_WIDTH = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_SCANS = 64
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [SCORE_WIDTH-1:0] i_Score,
  input  logic                   i_Score_Valid,
  input  logic                   i_Lz_Blank,
  input  logic                   i_Blink,
  output logic [7:0]             o_ScoreDisplay,
  output logic [NUM_DIGITS-1:0]  o_SegmentSelect,
  output logic                   o_Busy
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam int CNT_W  = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;

  // Largest value representable in NUM_DIGITS decimal digits.
  function automatic int pow10_minus1(input int n);
    int acc;
    acc = 1;
    for (int k = 0; k < n; k++) begin
      acc = acc * 10;
    end
    return acc - 1;
  endfunction

  localparam logic [31:0]       MAX_VAL   = 32'(pow10_minus1(NUM_DIGITS));
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(BLINK_SCANS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCORE_WIDTH - 1);

  // Clamp a raw score to the largest displayable value.
  function automatic logic [SCORE_WIDTH-1:0] sat_score(input logic [SCORE_WIDTH-1:0] s);
    logic [31:0] wide_v;
    wide_v = 32'(s);
    if (wide_v > MAX_VAL) begin
      sat_score = MAX_VAL[SCORE_WIDTH-1:0];
    end else begin
      sat_score = s;
    end
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = v[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {a,b,c,d,e,f,g,dp}; non-decimal nibbles go dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 8'b0000_0011;
      4'd1:    seg_decode = 8'b1001_1111;
      4'd2:    seg_decode = 8'b0010_0101;
      4'd3:    seg_decode = 8'b0000_1101;
      4'd4:    seg_decode = 8'b1001_1001;
      4'd5:    seg_decode = 8'b0100_1001;
      4'd6:    seg_decode = 8'b0100_0001;
      4'd7:    seg_decode = 8'b0001_1111;
      4'd8:    seg_decode = 8'b0000_0001;
      4'd9:    seg_decode = 8'b0000_1001;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [SCORE_WIDTH-1:0]  bin_r;
  logic [BCD_W-1:0]        bcd_r;
  logic [BCD_W-1:0]        add3_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [SCORE_WIDTH-1:0]  pend_score_r;
  logic                    pend_r;
  logic [BCD_W-1:0]        disp_r;
  logic                    busy_r;

  logic [REF_W-1:0]        ref_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [SCAN_W-1:0]       scan_cnt_r;
  logic                    phase_on_r;

  logic [NUM_DIGITS-1:0]   upper_zero_s;
  logic [3:0]              digit_s;
  logic                    blank_s;
  logic [7:0]              seg_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [7:0]              seg_r;
  logic [NUM_DIGITS-1:0]   sel_r;

  // Converter state register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Converter next-state logic; LATCH chains straight into a new conversion
  // when a score is waiting or arrives in that very cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_Score_Valid) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_LATCH;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        if (pend_r || i_Score_Valid) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Per-step nibble correction ahead of the shift.
  always_comb begin
    add3_s = add3_nibbles(bcd_r);
  end

  // Conversion datapath, single-entry pending slot and displayed BCD value.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      bin_r        <= {SCORE_WIDTH{1'b0}};
      bcd_r        <= {BCD_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      pend_score_r <= {SCORE_WIDTH{1'b0}};
      pend_r       <= 1'b0;
      disp_r       <= {BCD_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (i_Score_Valid) begin
            bin_r <= sat_score(i_Score);
            bcd_r <= {BCD_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          bcd_r <= {add3_s[BCD_W-2:0], bin_r[SCORE_WIDTH-1]};
          bin_r <= bin_r << 1'b1;
          cnt_r <= cnt_r + CNT_W'(1);
          if (i_Score_Valid) begin
            pend_score_r <= sat_score(i_Score);
            pend_r       <= 1'b1;
          end
        end
        ST_LATCH: begin
          disp_r <= bcd_r;
          pend_r <= 1'b0;
          if (i_Score_Valid) begin
            bin_r <= sat_score(i_Score);
            bcd_r <= {BCD_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
          end else if (pend_r) begin
            bin_r <= pend_score_r;
            bcd_r <= {BCD_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        default: begin
          pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Refresh divider, digit index, completed-scan counter and blink phase.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      ref_cnt_r  <= {REF_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      scan_cnt_r <= {SCAN_W{1'b0}};
      phase_on_r <= 1'b1;
    end else if (ref_cnt_r == REF_LAST) begin
      ref_cnt_r <= {REF_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
        if (scan_cnt_r == SCAN_LAST) begin
          scan_cnt_r <= {SCAN_W{1'b0}};
          phase_on_r <= ~phase_on_r;
        end else begin
          scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      ref_cnt_r <= ref_cnt_r + REF_W'(1);
    end
  end

  // upper_zero_s[k] is set when digits k..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic acc_v;
    upper_zero_s = {NUM_DIGITS{1'b0}};
    acc_v        = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc_v           = acc_v && (disp_r[4*k +: 4] == 4'd0);
      upper_zero_s[k] = acc_v;
    end
  end

  // Next segment/anode pattern for the currently indexed digit.
  always_comb begin
    digit_s = disp_r[int'(idx_r)*4 +: 4];
    blank_s = i_Lz_Blank && (idx_r != {IDX_W{1'b0}}) && upper_zero_s[idx_r];
    sel_s   = {NUM_DIGITS{1'b1}};
    seg_s   = 8'hFF;
    if (i_Blink && !phase_on_r) begin
      sel_s = {NUM_DIGITS{1'b1}};
      seg_s = 8'hFF;
    end else begin
      sel_s[idx_r] = 1'b0;
      if (blank_s) begin
        seg_s = 8'hFF;
      end else begin
        seg_s = seg_decode(digit_s);
      end
    end
  end

  // Output registers: segments and anodes move together.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      seg_r <= 8'hFF;
      sel_r <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r <= seg_s;
      sel_r <= sel_s;
    end
  end

  assign o_ScoreDisplay  = seg_r;
  assign o_SegmentSelect = sel_r;
  assign o_Busy          = busy_r;

endmodule

// File: tb/tb_snake_scoreboard_mux.sv
// Bench for snake_scoreboard_mux: directed scenarios plus random strobes,
// every cycle compared against a transaction-level model of score and scan.
module tb_snake_scoreboard_mux;

  localparam int ND = 4;
  localparam int SW = 14;
  localparam int RD = 4;
  localparam int BS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] score;
  logic          vld;
  logic          lz;
  logic          blink;
  logic [7:0]    seg;
  logic [ND-1:0] sel;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state (decimal values, edge counts)
  int   e;           // non-reset edges since reset release
  int   m_disp;      // displayed decimal value
  int   m_conv;      // value under conversion
  int   m_left;      // edges until the display update
  bit   m_busy;
  bit   m_pend;
  int   m_pend_val;
  int   p10 [ND+1];
  logic [7:0] seg_tab [10];

  snake_scoreboard_mux #(
    .NUM_DIGITS (ND),
    .SCORE_WIDTH(SW),
    .REFRESH_DIV(RD),
    .BLINK_SCANS(BS)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Score        (score),
    .i_Score_Valid  (vld),
    .i_Lz_Blank     (lz),
    .i_Blink        (blink),
    .o_ScoreDisplay (seg),
    .o_SegmentSelect(sel),
    .o_Busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int s);
    return (s > p10[ND] - 1) ? p10[ND] - 1 : s;
  endfunction

  // One clock: apply inputs, predict outputs from the pre-edge model, update, compare.
  task automatic step(input bit rst, input bit v, input int sc, input bit l, input bit b);
    logic [7:0]    exp_seg;
    logic [ND-1:0] exp_sel;
    bit            exp_busy;
    int            idx;
    bit            on;
    rst_n = ~rst;
    vld   = v;
    score = SW'(sc);
    lz    = l;
    blink = b;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_seg  = 8'hFF;
      exp_sel  = '1;
      e        = 0;
      m_disp   = 0;
      m_busy   = 1'b0;
      m_pend   = 1'b0;
      m_left   = 0;
      exp_busy = 1'b0;
    end else begin
      idx = (e / RD) % ND;
      on  = ((e / (RD * ND * BS)) % 2) == 0;
      if (b && !on) begin
        exp_seg = 8'hFF;
        exp_sel = '1;
      end else begin
        exp_sel      = '1;
        exp_sel[idx] = 1'b0;
        if (l && idx > 0 && m_disp < p10[idx]) exp_seg = 8'hFF;
        else exp_seg = seg_tab[(m_disp / p10[idx]) % 10];
      end
      e++;
      if (!m_busy) begin
        if (v) begin
          m_busy = 1'b1;
          m_conv = sat(sc);
          m_left = SW + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_conv;
          if (v) begin
            m_conv = sat(sc);
            m_left = SW + 1;
            m_pend = 1'b0;
          end else if (m_pend) begin
            m_conv = m_pend_val;
            m_left = SW + 1;
            m_pend = 1'b0;
          end else begin
            m_busy = 1'b0;
          end
        end else if (v) begin
          m_pend     = 1'b1;
          m_pend_val = sat(sc);
        end
      end
      exp_busy = m_busy;
    end
    check_val($sformatf("seg@%0t", $time), 32'(seg), 32'(exp_seg));
    check_val($sformatf("sel@%0t", $time), 32'(sel), 32'(exp_sel));
    check_val($sformatf("busy@%0t", $time), 32'(busy), 32'(exp_busy));
  endtask

  task automatic idle(input int n, input bit l, input bit b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, l, b);
  endtask

  initial begin
    bit r_lz;
    bit r_blink;
    p10[0] = 1;
    for (int i = 1; i <= ND; i++) p10[i] = p10[i-1] * 10;
    seg_tab[0] = 8'b0000_0011; seg_tab[1] = 8'b1001_1111;
    seg_tab[2] = 8'b0010_0101; seg_tab[3] = 8'b0000_1101;
    seg_tab[4] = 8'b1001_1001; seg_tab[5] = 8'b0100_1001;
    seg_tab[6] = 8'b0100_0001; seg_tab[7] = 8'b0001_1111;
    seg_tab[8] = 8'b0000_0001; seg_tab[9] = 8'b0000_1001;
    rst_n = 1'b0; vld = 1'b0; score = '0; lz = 1'b0; blink = 1'b0;
    e = 0; m_disp = 0; m_conv = 0; m_left = 0; m_busy = 1'b0; m_pend = 1'b0; m_pend_val = 0;

    // reset, then idle scan with and without blanking
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(20, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b0);

    // single conversion
    step(1'b0, 1'b1, 1234, 1'b0, 1'b0);
    idle(36, 1'b0, 1'b0);

    // strobes while busy: last one wins
    step(1'b0, 1'b1, 9999, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 12, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 345, 1'b0, 1'b0);
    idle(40, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b0);

    // saturation, then zero with blanking
    step(1'b0, 1'b1, 16383, 1'b0, 1'b0);
    idle(20, 1'b0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);

    // pending set, then a fresh strobe in the latch cycle
    step(1'b0, 1'b1, 50, 1'b0, 1'b0);
    idle(13, 1'b0, 1'b0);
    step(1'b0, 1'b1, 60, 1'b0, 1'b0);
    step(1'b0, 1'b1, 70, 1'b0, 1'b0);
    idle(36, 1'b0, 1'b0);

    // blink on and off
    idle(80, 1'b0, 1'b1);
    idle(6, 1'b0, 1'b0);

    // reset in the middle of a conversion
    step(1'b0, 1'b1, 777, 1'b0, 1'b0);
    idle(5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(20, 1'b0, 1'b0);

    // randomized traffic
    r_lz = 1'b0;
    r_blink = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 63) == 0) r_lz = ~r_lz;
      if ($urandom_range(0, 99) == 0) r_blink = ~r_blink;
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 16383)), r_lz, r_blink);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
